// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the integer ALU reservation station: ALU op codes,
// the RS entry and issue-register layouts, and the CDB capture helper.
package alu_reservation_station_pkg;

  localparam int ROB_PTR = 3;
  localparam int RS_SIZE = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef logic [ROB_PTR-1:0] rob_ix_t;

  typedef struct packed {
    logic               busy;
    alu_op_e            op;
    rob_ix_t            rob_ix;
    logic signed [31:0] vj;
    rob_ix_t            qj;
    logic               rj;
    logic signed [31:0] vk;
    rob_ix_t            qk;
    logic               rk;
  } rs_entry_t;

  typedef struct packed {
    logic               valid;
    alu_op_e            op;
    rob_ix_t            rob_ix;
    logic signed [31:0] vj;
    logic signed [31:0] vk;
  } issue_t;

  // Capture a CDB broadcast into any operand still waiting on its tag.
  // Used both for wakeup of stored entries and for dispatch bypass.
  function automatic rs_entry_t cdb_capture(input rs_entry_t e, input logic cdb_valid,
                                            input rob_ix_t tag, input logic signed [31:0] value);
    rs_entry_t r;
    r = e;
    if (cdb_valid && !e.rj && (e.qj == tag)) begin
      r.vj = value;
      r.rj = 1'b1;
    end
    if (cdb_valid && !e.rk && (e.qk == tag)) begin
      r.vk = value;
      r.rk = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
// master = surrounding pipeline, slave = reservation station.
interface alu_reservation_station_if #(
  parameter int SIZE    = 4,
  parameter int ROB_PTR = 3
);
  logic                     valid_in;
  logic [3:0]               op_in;
  logic [ROB_PTR-1:0]       rob_ix_in;
  logic signed [31:0]       vj_in;
  logic [ROB_PTR-1:0]       qj_in;
  logic                     rj_in;
  logic signed [31:0]       vk_in;
  logic [ROB_PTR-1:0]       qk_in;
  logic                     rk_in;
  logic                     ready_out;
  logic                     cdb_valid_in;
  logic [ROB_PTR-1:0]       cdb_rob_ix_in;
  logic signed [31:0]       cdb_value_in;
  logic                     fu_ready_in;
  logic                     issue_valid_out;
  logic [3:0]               issue_op_out;
  logic signed [31:0]       issue_vj_out;
  logic signed [31:0]       issue_vk_out;
  logic [ROB_PTR-1:0]       issue_rob_ix_out;
  logic [$clog2(SIZE):0]    occupancy_out;

  modport master (
    output valid_in, op_in, rob_ix_in, vj_in, qj_in, rj_in, vk_in, qk_in, rk_in,
    output cdb_valid_in, cdb_rob_ix_in, cdb_value_in, fu_ready_in,
    input  ready_out, issue_valid_out, issue_op_out, issue_vj_out, issue_vk_out,
    input  issue_rob_ix_out, occupancy_out
  );

  modport slave (
    input  valid_in, op_in, rob_ix_in, vj_in, qj_in, rj_in, vk_in, qk_in, rk_in,
    input  cdb_valid_in, cdb_rob_ix_in, cdb_value_in, fu_ready_in,
    output ready_out, issue_valid_out, issue_op_out, issue_vj_out, issue_vk_out,
    output issue_rob_ix_out, occupancy_out
  );
endinterface

// File: rtl/alu_reservation_station_rs_select.sv
// Combinational picker choosing which eligible RS entry issues next.
// Optional: RS_AGE_ORDER_EN selects the oldest eligible entry (age 0 = oldest);
// otherwise the lowest-index eligible entry wins.
module rs_select #(
  parameter  int SIZE = 4,
  localparam int IX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]            eligible_i,
`ifdef RS_AGE_ORDER_EN
  input  logic [SIZE-1:0][IX_W-1:0]  age_i,
`endif
  output logic [IX_W-1:0]            grant_o,
  output logic                       any_valid_o
);

`ifdef RS_AGE_ORDER_EN
  logic [IX_W-1:0] best_age;

  // Smallest age among eligible entries; busy ages are distinct so no ties.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_o     = '0;
    any_valid_o = 1'b0;
    best_age    = '1;
    for (int i = 0; i < SIZE; i++) begin
      if (eligible_i[i] && (!any_valid_o || (age_i[i] < best_age))) begin
        grant_o     = IX_W'(i);
        best_age    = age_i[i];
        any_valid_o = 1'b1;
      end
    end
  end
`else
  // Lowest-index eligible entry: scanning downward lets the lowest index win.
  always_comb begin
    grant_o     = '0;
    any_valid_o = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        grant_o     = IX_W'(i);
        any_valid_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station for the integer ALU: accepts dispatches,
// snoops the CDB for pending operands and issues ready work to the ALU
// through a single issue register with a valid/ready handshake.
// Optional: RS_AGE_ORDER_EN enables oldest-first selection via per-entry ages.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int ROB_PTR = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  alu_reservation_station_if.slave rs_if
);

  localparam int IX_W  = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE) + 1;

  rs_entry_t          entry_q [SIZE];
  rs_entry_t          entry_d [SIZE];
  issue_t             issue_q, issue_d;
  rs_entry_t          new_entry;
  logic [SIZE-1:0]    eligible;
  logic [IX_W-1:0]    grant, free_ix;
  logic               any_valid, issue_load, dispatch_fire, freeing;
  logic [CNT_W-1:0]   occ;
  logic [ROB_PTR-1:0] cdb_tag;

  assign cdb_tag = rs_if.cdb_rob_ix_in;

  // Occupancy, lowest free slot and eligibility, all from registered state.
  always_comb begin
    occ      = '0;
    free_ix  = '0;
    eligible = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      occ         = occ + CNT_W'(entry_q[i].busy);
      eligible[i] = entry_q[i].busy && entry_q[i].rj && entry_q[i].rk;
      if (!entry_q[i].busy) free_ix = IX_W'(i);
    end
  end

  assign rs_if.ready_out = (occ < CNT_W'(SIZE));
  assign dispatch_fire   = rs_if.valid_in && rs_if.ready_out;
  assign issue_load      = !issue_q.valid || rs_if.fu_ready_in;
  assign freeing         = issue_load && any_valid;

`ifdef RS_AGE_ORDER_EN
  logic [SIZE-1:0][IX_W-1:0] age_q, age_d;

  // Age rank: younger entries close the gap left by a freed entry; a new
  // entry takes the rank just behind everything that stays.
  always_comb begin
    age_d = age_q;
    if (freeing) begin
      for (int i = 0; i < SIZE; i++) begin
        if (entry_q[i].busy && (age_q[i] > age_q[grant])) age_d[i] = age_q[i] - 1'b1;
      end
    end
    if (dispatch_fire) age_d[free_ix] = IX_W'(occ - CNT_W'(freeing));
  end

  // Age rank register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) age_q <= '0;
    else        age_q <= age_d;
  end

  rs_select #(.SIZE(SIZE)) u_select (
    .eligible_i  (eligible),
    .age_i       (age_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );
`else
  rs_select #(.SIZE(SIZE)) u_select (
    .eligible_i  (eligible),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );
`endif

  // Next state: wakeup, issue-register load with entry free, dispatch with bypass.
  always_comb begin
    new_entry        = '0;
    new_entry.busy   = 1'b1;
    new_entry.op     = alu_op_e'(rs_if.op_in);
    new_entry.rob_ix = rs_if.rob_ix_in;
    new_entry.vj     = rs_if.vj_in;
    new_entry.qj     = rs_if.qj_in;
    new_entry.rj     = rs_if.rj_in;
    new_entry.vk     = rs_if.vk_in;
    new_entry.qk     = rs_if.qk_in;
    new_entry.rk     = rs_if.rk_in;

    issue_d = issue_q;
    for (int i = 0; i < SIZE; i++) begin
      entry_d[i] = entry_q[i].busy
                 ? cdb_capture(entry_q[i], rs_if.cdb_valid_in, cdb_tag, rs_if.cdb_value_in)
                 : entry_q[i];
    end

    if (issue_load) begin
      issue_d.valid = any_valid;
      if (any_valid) begin
        issue_d.op            = entry_q[grant].op;
        issue_d.rob_ix        = entry_q[grant].rob_ix;
        issue_d.vj            = entry_q[grant].vj;
        issue_d.vk            = entry_q[grant].vk;
        entry_d[grant].busy   = 1'b0;
      end
    end

    if (dispatch_fire) begin
      entry_d[free_ix] = cdb_capture(new_entry, rs_if.cdb_valid_in, cdb_tag, rs_if.cdb_value_in);
    end
  end

  // Entry array and issue register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the whole entry array is cleared, not just busy, so outputs and
      // payloads are deterministic after reset; the array is only SIZE entries.
      for (int i = 0; i < SIZE; i++) entry_q[i] <= '0;
      issue_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      for (int i = 0; i < SIZE; i++) entry_q[i] <= entry_d[i];
      issue_q <= issue_d;
    end
  end

  assign rs_if.issue_valid_out  = issue_q.valid;
  assign rs_if.issue_op_out     = issue_q.op;
  assign rs_if.issue_vj_out     = issue_q.vj;
  assign rs_if.issue_vk_out     = issue_q.vk;
  assign rs_if.issue_rob_ix_out = issue_q.rob_ix;
  assign rs_if.occupancy_out    = occ;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station (SIZE=4).
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_reservation_station_if #(.SIZE(4), .ROB_PTR(3)) bus ();

  alu_reservation_station #(.SIZE(4), .ROB_PTR(3)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rs_if  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [2:0] rob,
                          input logic [31:0] vj, input logic [2:0] qj, input logic rj,
                          input logic [31:0] vk, input logic [2:0] qk, input logic rk);
    bus.valid_in  = 1'b1;
    bus.op_in     = op;
    bus.rob_ix_in = rob;
    bus.vj_in     = vj;
    bus.qj_in     = qj;
    bus.rj_in     = rj;
    bus.vk_in     = vk;
    bus.qk_in     = qk;
    bus.rk_in     = rk;
    tick();
    bus.valid_in  = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] value);
    bus.cdb_valid_in  = 1'b1;
    bus.cdb_rob_ix_in = tag;
    bus.cdb_value_in  = value;
    tick();
    bus.cdb_valid_in  = 1'b0;
  endtask

  int         occ_exp [6] = '{1, 1, 2, 3, 4, 4};
`ifdef RS_AGE_ORDER_EN
  logic [2:0] full_order [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [2:0] age_order  [3] = '{3'd3, 3'd1, 3'd2};
`else
  logic [2:0] full_order [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
  logic [2:0] age_order  [3] = '{3'd1, 3'd2, 3'd3};
`endif

  initial begin
    rst               = 1'b1;
    bus.valid_in      = 1'b0;
    bus.op_in         = '0;
    bus.rob_ix_in     = '0;
    bus.vj_in         = '0;
    bus.qj_in         = '0;
    bus.rj_in         = 1'b0;
    bus.vk_in         = '0;
    bus.qk_in         = '0;
    bus.rk_in         = 1'b0;
    bus.cdb_valid_in  = 1'b0;
    bus.cdb_rob_ix_in = '0;
    bus.cdb_value_in  = '0;
    bus.fu_ready_in   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_issue_valid", 32'(bus.issue_valid_out), 32'd0);
    check("rst_issue_vj",    bus.issue_vj_out, 32'd0);
    check("rst_occupancy",   32'(bus.occupancy_out), 32'd0);
    check("rst_ready",       32'(bus.ready_out), 32'd1);
    rst = 1'b0;
    tick();

    // Ready-operand issue: 1-cycle dispatch-to-issue latency
    dispatch(ALU_ADD, 3'd2, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0, 1'b1);
    check("add_occ_after_dispatch", 32'(bus.occupancy_out), 32'd1);
    check("add_valid_early",        32'(bus.issue_valid_out), 32'd0);
    tick();
    check("add_valid", 32'(bus.issue_valid_out), 32'd1);
    check("add_op",    32'(bus.issue_op_out), 32'(ALU_ADD));
    check("add_vj",    bus.issue_vj_out, 32'd5);
    check("add_vk",    bus.issue_vk_out, 32'd7);
    check("add_rob",   32'(bus.issue_rob_ix_out), 32'd2);
    check("add_occ",   32'(bus.occupancy_out), 32'd0);
    tick();
    check("add_drained", 32'(bus.issue_valid_out), 32'd0);

    // CDB wakeup of operand j
    dispatch(ALU_SUB, 3'd1, 32'd0, 3'd4, 1'b0, 32'd1, 3'd0, 1'b1);
    tick();
    check("wake_wait", 32'(bus.issue_valid_out), 32'd0);
    cdb(3'd4, -32'sd3);
    check("wake_not_yet", 32'(bus.issue_valid_out), 32'd0);
    tick();
    check("wake_valid", 32'(bus.issue_valid_out), 32'd1);
    check("wake_vj",    bus.issue_vj_out, 32'hFFFF_FFFD);
    check("wake_vk",    bus.issue_vk_out, 32'd1);
    check("wake_rob",   32'(bus.issue_rob_ix_out), 32'd1);
    tick();
    check("wake_drained", 32'(bus.issue_valid_out), 32'd0);

    // Dispatch bypass on j, then on k
    bus.cdb_valid_in = 1'b1; bus.cdb_rob_ix_in = 3'd6; bus.cdb_value_in = 32'h1234;
    dispatch(ALU_AND, 3'd6, 32'hDEAD, 3'd6, 1'b0, 32'h55, 3'd0, 1'b1);
    bus.cdb_valid_in = 1'b0;
    tick();
    check("byp_j_valid", 32'(bus.issue_valid_out), 32'd1);
    check("byp_j_vj",    bus.issue_vj_out, 32'h1234);
    bus.cdb_valid_in = 1'b1; bus.cdb_rob_ix_in = 3'd5; bus.cdb_value_in = 32'hABCD;
    dispatch(ALU_OR, 3'd5, 32'd9, 3'd0, 1'b1, 32'hBEEF, 3'd5, 1'b0);
    bus.cdb_valid_in = 1'b0;
    check("byp_k_prev_gone", 32'(bus.issue_rob_ix_out), 32'd6);
    tick();
    check("byp_k_valid", 32'(bus.issue_valid_out), 32'd1);
    check("byp_k_vk",    bus.issue_vk_out, 32'hABCD);
    check("byp_k_rob",   32'(bus.issue_rob_ix_out), 32'd5);
    tick();
    check("byp_drained", 32'(bus.issue_valid_out), 32'd0);

    // Full / backpressure: SIZE+1 fit (entries + issue reg), the next is ignored
    bus.fu_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.valid_in = 1'b1; bus.op_in = ALU_ADD; bus.rob_ix_in = 3'(i);
      bus.vj_in = 32'(100 + i); bus.rj_in = 1'b1; bus.vk_in = 32'd0; bus.rk_in = 1'b1;
      tick();
      check($sformatf("full_occ_%0d", i), 32'(bus.occupancy_out), 32'(occ_exp[i]));
    end
    bus.valid_in = 1'b0;
    check("full_ready", 32'(bus.ready_out), 32'd0);
    for (int h = 0; h < 2; h++) begin
      tick();
      check("hold_valid", 32'(bus.issue_valid_out), 32'd1);
      check("hold_rob",   32'(bus.issue_rob_ix_out), 32'd0);
      check("hold_vj",    bus.issue_vj_out, 32'd100);
    end
    bus.fu_ready_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("drain_rob_%0d", j), 32'(bus.issue_rob_ix_out), 32'(full_order[j]));
      check($sformatf("drain_vj_%0d", j),  bus.issue_vj_out, 32'(100 + 32'(full_order[j])));
      if (j == 0) check("drain_ready", 32'(bus.ready_out), 32'd1);
    end
    tick();
    check("drain_empty_valid", 32'(bus.issue_valid_out), 32'd0);
    check("drain_empty_occ",   32'(bus.occupancy_out), 32'd0);

    // Ordering: entries 3,1,2 filled in that age order
    bus.fu_ready_in = 1'b0;
    dispatch(ALU_ADD, 3'd0, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1);  // H -> issue reg
    tick();
    dispatch(ALU_ADD, 3'd4, 32'd0, 3'd3, 1'b0, 32'd0, 3'd0, 1'b1);  // G  -> e0
    dispatch(ALU_ADD, 3'd6, 32'd0, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1);  // F1 -> e1
    dispatch(ALU_ADD, 3'd7, 32'd0, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1);  // F2 -> e2
    dispatch(ALU_ADD, 3'd3, 32'd0, 3'd2, 1'b0, 32'd0, 3'd0, 1'b1);  // D3 -> e3
    cdb(3'd1, 32'd11);
    bus.fu_ready_in = 1'b1;
    tick();
    check("ord_f1", 32'(bus.issue_rob_ix_out), 32'd6);
    tick();
    check("ord_f2", 32'(bus.issue_rob_ix_out), 32'd7);
    bus.fu_ready_in = 1'b0;
    dispatch(ALU_ADD, 3'd1, 32'd0, 3'd4, 1'b0, 32'd0, 3'd0, 1'b1);  // N1 -> e1
    dispatch(ALU_ADD, 3'd2, 32'd0, 3'd4, 1'b0, 32'd0, 3'd0, 1'b1);  // N2 -> e2
    cdb(3'd2, 32'd22);
    cdb(3'd4, 32'd44);
    check("ord_occ", 32'(bus.occupancy_out), 32'd4);
    bus.fu_ready_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("ord_rob_%0d", j), 32'(bus.issue_rob_ix_out), 32'(age_order[j]));
    end
    cdb(3'd3, 32'd33);
    check("ord_gap", 32'(bus.issue_valid_out), 32'd0);
    tick();
    check("ord_g_rob", 32'(bus.issue_rob_ix_out), 32'd4);
    check("ord_g_vj",  bus.issue_vj_out, 32'd33);
    tick();
    check("ord_empty_valid", 32'(bus.issue_valid_out), 32'd0);
    check("ord_empty_occ",   32'(bus.occupancy_out), 32'd0);

    // Asynchronous reset mid-operation
    bus.fu_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) dispatch(ALU_XOR, 3'(i), 32'(7 + i), 3'd0, 1'b1, 32'd0, 3'd0, 1'b1);
    check("mid_pre_occ", 32'(bus.occupancy_out), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.issue_valid_out), 32'd0);
    check("mid_rst_occ",   32'(bus.occupancy_out), 32'd0);
    check("mid_rst_ready", 32'(bus.ready_out), 32'd1);
    check("mid_rst_vj",    bus.issue_vj_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(bus.issue_valid_out), 32'd0);
    check("post_rst_occ",   32'(bus.occupancy_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
